// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel request queue.
//   DATA_W      : width of sizes and addresses
//   ALIGN_BYTES : allocation granule; sizes round up to it, free addresses must sit on it
//   req_entry_t : one queued request (type + payload)
//   align_up()  : rounds a size up to the granule; bit DATA_W is the carry-out
package falafel_pkg;

    localparam int DATA_W      = 32;
    localparam int ALIGN_BYTES = 8;

    typedef struct packed {
        logic              is_alloc;
        logic [DATA_W-1:0] data;
    } req_entry_t;

    function automatic logic [DATA_W:0] align_up(input logic [DATA_W-1:0] size);
        logic [DATA_W:0] sum;
        sum = {1'b0, size} + (DATA_W+1)'(ALIGN_BYTES - 1);
        sum[$clog2(ALIGN_BYTES)-1:0] = '0;
        return sum;
    endfunction

endpackage

// File: rtl/falafel_req_queue_if.sv
// Client/allocator bundle for falafel_req_queue.
//   master : the client plus allocator side (drives requests and core_ready_i)
//   slave  : the queue itself
// Signal names keep the queue-relative _i/_o suffixes so they match the block's
// documented pin list.
interface falafel_req_queue_if import falafel_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_val_i;
    logic              req_rdy_o;
    logic              req_is_alloc_i;
    logic [DATA_W-1:0] req_data_i;
    logic              req_alloc_valid_o;
    logic              core_ready_i;
    logic              is_alloc_o;
    logic [DATA_W-1:0] size_to_allocate_o;
    logic [DATA_W-1:0] addr_to_free_o;
    logic [CNT_W-1:0]  count_o;
    logic [ERR_W-1:0]  err_cnt_o;

    modport master (
        output req_val_i, req_is_alloc_i, req_data_i, core_ready_i,
        input  req_rdy_o, req_alloc_valid_o, is_alloc_o, size_to_allocate_o,
               addr_to_free_o, count_o, err_cnt_o
    );

    modport slave (
        input  req_val_i, req_is_alloc_i, req_data_i, core_ready_i,
        output req_rdy_o, req_alloc_valid_o, is_alloc_o, size_to_allocate_o,
               addr_to_free_o, count_o, err_cnt_o
    );

endinterface

// File: rtl/falafel_fifo.sv
// Generic synchronous FIFO, no bypass: a push becomes visible at head_o the
// cycle after it is written.
//   clk_i, rst_i : clock, asynchronous active-high reset (pointers/count only)
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : oldest entry; undefined while empty_o=1
//   full_o, empty_o, count_o : occupancy
module falafel_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage has no reset; callers gate head_o with empty_o.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/falafel_req_queue.sv
// Allocator request queue. Validates and normalises alloc/free requests from a
// client, buffers them in order and presents the oldest one to the allocator.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : falafel_req_queue_if.slave (request in, head out, count, errors)
// Malformed requests (zero size, size that overflows when rounded, unaligned
// free address) are still handshaken so the client never stalls on them; they
// are dropped and counted in a saturating error counter.
module falafel_req_queue import falafel_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    falafel_req_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(ALIGN_BYTES - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("falafel_req_queue: DEPTH must be a power of two >= 2");
    end

    logic              accept;
    logic [DATA_W:0]   size_up;
    logic              bad_req;
    logic              push;
    req_entry_t        push_entry;
    req_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [ERR_W-1:0]  err_cnt;

    assign accept  = bus.req_val_i && bus.req_rdy_o;
    assign size_up = align_up(bus.req_data_i);

    always_comb begin
        bad_req = 1'b0;
        push_entry.is_alloc = bus.req_is_alloc_i;
        push_entry.data     = bus.req_data_i;
        if (bus.req_is_alloc_i) begin
            bad_req         = (bus.req_data_i == '0) || size_up[DATA_W];
            push_entry.data = size_up[DATA_W-1:0];
        end else begin
            bad_req = (bus.req_data_i & ALIGN_MASK) != '0;
        end
    end

    assign push = accept && !bad_req;
    assign pop  = bus.req_alloc_valid_o && bus.core_ready_i;

    falafel_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (accept && bad_req && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Full blocks acceptance even if the head issues this cycle (no pass-through).
    assign bus.req_rdy_o         = !fifo_full;
    assign bus.req_alloc_valid_o = !fifo_empty;
    assign bus.count_o           = count;
    assign bus.err_cnt_o         = err_cnt;

    // Head fields are masked while empty so unreset storage never leaks out.
    assign bus.is_alloc_o         = !fifo_empty && head.is_alloc;
    assign bus.size_to_allocate_o = (!fifo_empty && head.is_alloc)  ? head.data : '0;
    assign bus.addr_to_free_o     = (!fifo_empty && !head.is_alloc) ? head.data : '0;

endmodule

// File: tb/tb_falafel_req_queue.sv
module tb_falafel_req_queue;
    import falafel_pkg::*;

    localparam int DEPTH = 4;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    typedef struct {
        bit          is_alloc;
        logic [31:0] data;
    } m_entry_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    falafel_req_queue_if #(.DEPTH(DEPTH), .ERR_W(ERR_W)) bus ();

    falafel_req_queue #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int       n_assert = 0;
    int       n_fail   = 0;
    m_entry_t m_q[$];
    int       m_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit          e_alloc;
        logic [31:0] e_size;
        logic [31:0] e_addr;
        e_alloc = 1'b0;
        e_size  = '0;
        e_addr  = '0;
        if (m_q.size() != 0) begin
            e_alloc = m_q[0].is_alloc;
            if (m_q[0].is_alloc) e_size = m_q[0].data;
            else                 e_addr = m_q[0].data;
        end
        check({tag, ".rdy"},   bus.req_rdy_o,         (m_q.size() != DEPTH));
        check({tag, ".valid"}, bus.req_alloc_valid_o, (m_q.size() != 0));
        check({tag, ".alloc"}, bus.is_alloc_o,        e_alloc);
        check({tag, ".size"},  bus.size_to_allocate_o, e_size);
        check({tag, ".addr"},  bus.addr_to_free_o,    e_addr);
        check({tag, ".count"}, bus.count_o,           m_q.size());
        check({tag, ".err"},   bus.err_cnt_o,         m_err);
    endtask

    // Called just after a rising edge: drive, check the pre-edge view at the
    // falling edge, then advance the reference model across the next edge.
    task automatic step(input string tag, input bit val, input bit is_alloc,
                        input logic [31:0] data, input bit core_rdy);
        bit              acc;
        bit              iss;
        longint unsigned rounded;
        bit              bad;
        m_entry_t        e;
        bus.req_val_i      = val;
        bus.req_is_alloc_i = is_alloc;
        bus.req_data_i     = data;
        bus.core_ready_i   = core_rdy;
        @(negedge clk_i);
        check_all(tag);
        acc = val && (m_q.size() < DEPTH);
        iss = core_rdy && (m_q.size() > 0);
        @(posedge clk_i);
        if (iss) void'(m_q.pop_front());
        if (acc) begin
            if (is_alloc) begin
                rounded = ((longint'({32'b0, data}) + ALIGN_BYTES - 1) / ALIGN_BYTES) * ALIGN_BYTES;
                bad = (data == 0) || (rounded > 64'hFFFF_FFFF);
                e.data = rounded[31:0];
            end else begin
                bad = (data % ALIGN_BYTES) != 0;
                e.data = data;
            end
            e.is_alloc = is_alloc;
            if (bad) begin
                if (m_err < ERR_MAX) m_err++;
            end else begin
                m_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input bit core_rdy);
        step("idle", 1'b0, 1'b0, 32'h0, core_rdy);
    endtask

    initial begin
        int          kind;
        logic [31:0] d;
        bit          a;
        bus.req_val_i      = 1'b0;
        bus.req_is_alloc_i = 1'b0;
        bus.req_data_i     = '0;
        bus.core_ready_i   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        rst_i = 1'b0;

        // Alloc 13 rounds to 16 and appears the following cycle
        step("a13", 1'b1, 1'b1, 32'd13, 1'b0);
        idle(1'b0);
        check("a13_size_16", bus.size_to_allocate_o, 32'd16);
        idle(1'b1);
        idle(1'b0);

        // Fill to DEPTH with five back-to-back requests, then drain in order
        step("fill0", 1'b1, 1'b1, 32'd1,     1'b0);
        step("fill1", 1'b1, 1'b0, 32'h100,   1'b0);
        step("fill2", 1'b1, 1'b1, 32'd24,    1'b0);
        step("fill3", 1'b1, 1'b0, 32'h2008,  1'b0);
        step("fill4", 1'b1, 1'b1, 32'd77,    1'b0);
        check("full_rdy_0",  bus.req_rdy_o, 1'b0);
        check("full_count4", bus.count_o,   4);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Three invalid requests
        step("bad_a0",  1'b1, 1'b1, 32'd0,          1'b0);
        step("bad_f",   1'b1, 1'b0, 32'h1003,       1'b0);
        step("bad_ovf", 1'b1, 1'b1, 32'hFFFF_FFFD,  1'b0);
        idle(1'b0);
        check("err_3",    bus.err_cnt_o, 3);
        check("err_cnt0", bus.count_o,   0);

        // Largest size that still fits and an aligned top address
        step("max_ok",  1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        step("top_fr",  1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Steady occupancy 2 with concurrent push/issue across pointer wrap
        step("pre0", 1'b1, 1'b1, 32'd5,  1'b0);
        step("pre1", 1'b1, 1'b0, 32'h40, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("wrap", 1'b1, i[0], 32'(8 * (i + 3)), 1'b1);
            check("wrap_count2", bus.count_o, 2);
        end
        idle(1'b1);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin a = 1'b1; d = 32'd0; end
                1: begin a = 1'b1; d = $urandom_range(1, 200); end
                2: begin a = 1'b1; d = 32'hFFFF_FFF0 + $urandom_range(0, 15); end
                3: begin a = 1'b0; d = $urandom & 32'hFFFF_FFF8; end
                4: begin a = 1'b0; d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(1, 7)); end
                default: begin a = 1'b1; d = $urandom; end
            endcase
            step("rand", ($urandom_range(0, 3) != 0), a, d, ($urandom_range(0, 2) != 0));
        end

        // Error counter saturation
        for (int i = 0; i < 300; i++) step("sat", 1'b1, 1'b1, 32'd0, 1'b1);
        idle(1'b1);
        check("err_sat_255", bus.err_cnt_o, 255);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 8; i++) idle(1'b1);
        step("q0", 1'b1, 1'b1, 32'd9,   1'b0);
        step("q1", 1'b1, 1'b0, 32'h80,  1'b0);
        step("q2", 1'b1, 1'b1, 32'd100, 1'b0);
        bus.req_val_i = 1'b0;
        check("pre_rst_count3", bus.count_o, 3);
        #2;
        rst_i = 1'b1;
        #1;
        m_q.delete();
        m_err = 0;
        check_all("async_rst");
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_all("post_rst");
        step("post_push", 1'b1, 1'b1, 32'd40, 1'b1);
        idle(1'b0);
        check("post_alone_cnt",  bus.count_o, 1);
        check("post_alone_size", bus.size_to_allocate_o, 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
